outbox_fifo: RTL and testbench
==============================

Name: outbox_fifo

Overview:
- Output side of the HRM datapath: the CPU's OUTBOX instruction writes register R here, and an external consumer drains it.
- Buffers signed 8-bit values from R in a DEPTH-entry FIFO.
- Presents the head entry to the consumer with a valid/ready handshake.
- Reports full/empty/count to the control unit, which stalls the OUTBOX instruction on full.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- WIDTH, 8, data width in bits; matches the R register width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- iR  in  WIDTH  value of register R; stored unmodified (two's complement).
- wO  in  1  push request from the control unit (OUTBOX instruction).
- iClear  in  1  synchronous flush of all contents.
- oData  out  WIDTH  head-of-FIFO value (first-word fall-through).
- oValid  out  1  oData holds a valid entry.
- iReady  in  1  consumer accepts oData this cycle.
- oFull  out  1  count == DEPTH.
- oEmpty  out  1  count == 0.
- oCount  out  $clog2(DEPTH)+1  current number of entries.
- oOverflow  out  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count = 0; oValid = 0; oData = 0.
  - oEmpty = 1; oFull = 0; oOverflow = 0.
  - Memory contents are don't-care.
- Push: accepted when wO && !oFull. iR is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Push on full (wO && oFull):
  - Data is dropped and the pointers do not move.
  - oOverflow sets to 1 on the next edge and stays set until reset or iClear.
  - A simultaneous pop does not rescue the push. The control unit must stall on oFull.
- Pop: occurs when oValid && iReady. rd_ptr increments modulo DEPTH. iReady with oValid = 0 has no effect.
- oValid = !oEmpty, combinational from registered count.
- oData = mem[rd_ptr].
- Latency: a value pushed at edge N appears on oData with oValid = 1 after edge N when the FIFO was empty. The same cycle's wO is not bypassed to oData.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous accepted push and pop, valid whenever 0 < count < DEPTH.
- Empty with wO: the push is accepted and no pop happens that cycle (oValid was 0).
- Full with iReady: the pop is accepted and count becomes DEPTH−1. A wO in the same cycle is dropped and flagged.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. FIFO order is preserved across the wrap.
- iClear:
  - On the next edge, pointers and count = 0 and oOverflow = 0.
  - Overrides any push or pop in the same cycle.
  - oData returns to don't-care and oValid = 0.
- Reset asserted mid-transfer: all entries are lost immediately. oValid drops asynchronously.
- Non-synthesis build: print "%t DEBUG OUTBOX=%h" on every accepted push.
- Formal build:
  - Assert count <= DEPTH.
  - Assert oFull and oEmpty are never both 1.
  - Assert oValid == !oEmpty.
  - Assert ^oData has no X/Z whenever oValid.

Decomposition:
- Shared package hrm_pkg:
  - DATA_W = 8 constant.
  - Signed data typedef.
  - Default OUTBOX_DEPTH = 8.
- One natural sub-module: outbox_mem.
  - Simple dual-port register array, one write port and one asynchronous read port, parameterised by DEPTH/WIDTH.
  - The pointer, count and flag logic stays in outbox_fifo.

Test Plan:
1. Reset, then push 8'h05, 8'hFB (−5), 8'h7F with iReady = 0 → oCount = 3 and oData = 8'h05. Then iReady = 1 for 3 cycles → oData sequence 05, FB, 7F, then oValid = 0 and oEmpty = 1.
2. Push 8 values 8'h10..8'h17 → oFull = 1 and oCount = 8. Push 8'hAA → oOverflow = 1, oCount stays 8, and a full drain returns exactly 10..17.
3. With 3 entries held, assert wO = 1 and iReady = 1 together for 4 cycles with data 8'h20..8'h23 → oCount stays 3. Output order is the original 3 entries followed by 20.
4. Wrap-around: 20 push/pop pairs of incrementing data (8'h00..8'h13) with DEPTH = 8 → every value emerges in order and no pop occurs with oValid = 0.
5. With 5 entries held and oOverflow set, pulse iClear with wO = 1 in the same cycle → next cycle oCount = 0, oEmpty = 1, oValid = 0, oOverflow = 0.
6. Drop rst_n asynchronously mid-cycle with 4 entries held → oValid = 0 and oCount = 0 before the next clk edge. After release, the first push of 8'h3C appears at oData one edge later.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared HRM datapath definitions: data width, signed data type and default OUTBOX depth.
package hrm_pkg;

   localparam int unsigned DATA_W       = 8;
   localparam int unsigned OUTBOX_DEPTH = 8;

   typedef logic signed [DATA_W-1:0] data_t;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/outbox_fifo_if.sv
// OUTBOX bundle: producer push, consumer valid/ready and status back to the control unit.
interface outbox_fifo_if
   import hrm_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned DEPTH = OUTBOX_DEPTH
);
   localparam int unsigned CntW = cnt_w(DEPTH);

   logic [WIDTH-1:0] iR;
   logic             wO;
   logic             iClear;
   logic [WIDTH-1:0] oData;
   logic             oValid;
   logic             iReady;
   logic             oFull;
   logic             oEmpty;
   logic [CntW-1:0]  oCount;
   logic             oOverflow;

   modport master (
      output iR, wO, iClear, iReady,
      input  oData, oValid, oFull, oEmpty, oCount, oOverflow
   );

   modport slave (
      input  iR, wO, iClear, iReady,
      output oData, oValid, oFull, oEmpty, oCount, oOverflow
   );

endinterface

// File: rtl/outbox_mem.sv
// Register-array storage for the OUTBOX FIFO: one synchronous write port, one async read port.
module outbox_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/outbox_fifo.sv
// OUTBOX FIFO: buffers register R values for an external consumer, first-word fall-through.
module outbox_fifo
   import hrm_pkg::*;
#(
   parameter int unsigned DEPTH = OUTBOX_DEPTH,
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   outbox_fifo_if.slave  bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = cnt_w(DEPTH);

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full, empty, push, pop, mem_we;
   logic [WIDTH-1:0] rd_data;

   always_comb begin
      full  = (count_q == CntW'(DEPTH));
      empty = (count_q == '0);
      push  = bus.wO && !full;
      pop   = !empty && bus.iReady;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;

      // Clear wins over any push or pop in the same cycle.
      if (bus.iClear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         mem_we = push;
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push) - CntW'(pop);
         if (bus.wO && full) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   outbox_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.iR),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   // Head is masked while empty so reset presents zero rather than stale memory.
   always_comb begin
      bus.oValid    = !empty;
      bus.oData     = empty ? '0 : rd_data;
      bus.oFull     = full;
      bus.oEmpty    = empty;
      bus.oCount    = count_q;
      bus.oOverflow = ovf_q;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         $display("%t DEBUG OUTBOX=%h", $time, bus.iR);
      end
   end
`endif

`ifdef FORMAL
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CntW'(DEPTH));
   a_full_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.oFull && bus.oEmpty));
   a_valid: assert property (@(posedge clk) disable iff (!rst_n)
      bus.oValid == !bus.oEmpty);
   a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
      bus.oValid |-> !$isunknown(^bus.oData));
`endif

endmodule

// File: tb/tb_outbox_fifo.sv
// Directed bench for outbox_fifo: queue-based model checked every cycle plus literal spot checks.
module tb_outbox_fifo;
   import hrm_pkg::*;

   localparam int unsigned Depth = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] mq[$];
   logic       m_ovf;
   logic [7:0] got[$];

   outbox_fifo_if #(.WIDTH(8), .DEPTH(Depth)) f ();

   outbox_fifo #(.DEPTH(Depth), .WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (f)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO as a queue, applying the accept/drop/clear rules directly.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (f.iClear) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         automatic bit do_pop  = (mq.size() > 0) && f.iReady;
         automatic bit do_push = f.wO && (mq.size() < Depth);
         if (f.wO && mq.size() == Depth) m_ovf = 1'b1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(f.iR);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("count", 32'(f.oCount), mq.size());
         chk("valid", 32'(f.oValid), 32'(mq.size() > 0));
         chk("empty", 32'(f.oEmpty), 32'(mq.size() == 0));
         chk("full", 32'(f.oFull), 32'(mq.size() == Depth));
         chk("overflow", 32'(f.oOverflow), 32'(m_ovf));
         if (mq.size() > 0) chk("head", 32'(f.oData), 32'(mq[0]));
      end
   end

   task automatic step(input logic w, input logic [7:0] d, input logic rdy, input logic clr);
      f.wO = w;
      f.iR = d;
      f.iReady = rdy;
      f.iClear = clr;
      if (f.oValid && rdy && !clr) got.push_back(f.oData);
      @(posedge clk);
      #2;
      f.wO = 1'b0;
      f.iReady = 1'b0;
      f.iClear = 1'b0;
   endtask

   task automatic check_got(input string name, input logic [7:0] exp[$]);
      chk({name, "_n"}, got.size(), exp.size());
      foreach (exp[i]) begin
         if (i < got.size()) chk(name, 32'(got[i]), 32'(exp[i]));
      end
      got.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp[$];
      f.iR = '0;
      f.wO = 1'b0;
      f.iClear = 1'b0;
      f.iReady = 1'b0;

      #1;
      chk("rst_valid", 32'(f.oValid), 0);
      chk("rst_empty", 32'(f.oEmpty), 1);
      chk("rst_full", 32'(f.oFull), 0);
      chk("rst_count", 32'(f.oCount), 0);
      chk("rst_ovf", 32'(f.oOverflow), 0);
      chk("rst_data", 32'(f.oData), 0);
      #11 rst_n = 1'b1;

      // 1: basic push then drain, including a negative value
      step(1, 8'h05, 0, 0);
      step(1, 8'hFB, 0, 0);
      step(1, 8'h7F, 0, 0);
      chk("t1_count", 32'(f.oCount), 3);
      chk("t1_head", 32'(f.oData), 32'h05);
      repeat (3) step(0, 8'h00, 1, 0);
      exp = '{8'h05, 8'hFB, 8'h7F};
      check_got("t1_order", exp);
      chk("t1_valid", 32'(f.oValid), 0);
      chk("t1_empty", 32'(f.oEmpty), 1);

      // 2: fill, overflow on full, drain
      for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 0, 0);
      chk("t2_full", 32'(f.oFull), 1);
      chk("t2_count", 32'(f.oCount), 8);
      step(1, 8'hAA, 0, 0);
      chk("t2_ovf", 32'(f.oOverflow), 1);
      chk("t2_count_held", 32'(f.oCount), 8);
      repeat (9) step(0, 8'h00, 1, 0);
      exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
      check_got("t2_order", exp);
      chk("t2_ovf_sticky", 32'(f.oOverflow), 1);

      // 2b: full with simultaneous pop and push: pop wins, push dropped
      step(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0, 0);
      step(1, 8'hBB, 1, 0);
      chk("t2b_count", 32'(f.oCount), 7);
      chk("t2b_ovf", 32'(f.oOverflow), 1);
      chk("t2b_head", 32'(f.oData), 32'h41);
      got.delete();

      // 3: simultaneous push/pop at mid occupancy
      step(0, 8'h00, 0, 1);
      chk("t3_clear_ovf", 32'(f.oOverflow), 0);
      step(1, 8'h31, 0, 0);
      step(1, 8'h32, 0, 0);
      step(1, 8'h33, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 1, 0);
      chk("t3_count", 32'(f.oCount), 3);
      exp = '{8'h31, 8'h32, 8'h33, 8'h20};
      check_got("t3_order", exp);

      // 4: wrap-around with paired push/pop
      step(0, 8'h00, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 8'(i), 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      exp.delete();
      for (int i = 0; i < 20; i++) exp.push_back(8'(i));
      check_got("t4_order", exp);
      chk("t4_empty", 32'(f.oEmpty), 1);

      // 5: clear overrides a push, with overflow set and 5 entries held
      for (int i = 0; i < 9; i++) step(1, 8'h50 + 8'(i), 0, 0);
      repeat (3) step(0, 8'h00, 1, 0);
      got.delete();
      chk("t5_pre_count", 32'(f.oCount), 5);
      chk("t5_pre_ovf", 32'(f.oOverflow), 1);
      step(1, 8'h99, 0, 1);
      chk("t5_count", 32'(f.oCount), 0);
      chk("t5_empty", 32'(f.oEmpty), 1);
      chk("t5_valid", 32'(f.oValid), 0);
      chk("t5_ovf", 32'(f.oOverflow), 0);

      // 6: asynchronous reset mid-cycle
      for (int i = 0; i < 4; i++) step(1, 8'h60 + 8'(i), 0, 0);
      chk("t6_pre_count", 32'(f.oCount), 4);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(f.oValid), 0);
      chk("t6_count", 32'(f.oCount), 0);
      #2 rst_n = 1'b1;
      step(1, 8'h3C, 0, 0);
      chk("t6_data", 32'(f.oData), 32'h3C);
      chk("t6_valid_after", 32'(f.oValid), 1);
      step(0, 8'h00, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
